// File: rtl/timer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timer_ctrl_pkg
//  Description : Shared types and constants for the alarm sequencing
//                controller: state encoding, datapath mux select codes,
//                counter width and small state-decode helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package timer_ctrl_pkg;

    // Width of the shared ring/snooze second counter
    localparam int unsigned CNT_W = 10;

    // Datapath mux select codes
    localparam logic [1:0] SEL_ENTRY = 2'b00;
    localparam logic [1:0] SEL_LIVE  = 2'b01;
    localparam logic [1:0] SEL_ALARM = 2'b10;

    // Controller state codes; the numeric values are visible on the debug port
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_CLEAR  = 4'd1,
        ST_LOAD_A = 4'd2,
        ST_ARMED  = 4'd3,
        ST_LOAD_B = 4'd4,
        ST_CMP    = 4'd5,
        ST_EVAL   = 4'd6,
        ST_RING   = 4'd7,
        ST_SNOOZE = 4'd8
    } state_t;

    // Mux select driven while in a given state
    function automatic logic [1:0] sel_for_state(input state_t st);
        logic [1:0] sel;
        sel = SEL_ENTRY;
        case (st)
            ST_LOAD_B, ST_CMP, ST_EVAL: sel = SEL_LIVE;
            ST_RING:                    sel = SEL_ALARM;
            default:                    sel = SEL_ENTRY;
        endcase
        return sel;
    endfunction

    // States during which the datapath is being sequenced
    function automatic logic is_busy_state(input state_t st);
        logic b;
        b = 1'b0;
        case (st)
            ST_CLEAR, ST_LOAD_A, ST_LOAD_B, ST_CMP, ST_EVAL: b = 1'b1;
            default:                                          b = 1'b0;
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sec_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sec_counter
//  Description : Loadable tick-driven down-counter shared by the RING and
//                SNOOZE periods. Load wins over decrement; the count holds
//                at zero. Flags report zero and a count of exactly one.
//  Revision    : 1.0 - initial release
// ============================================================================
module sec_counter
    import timer_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o,
    output logic             one_o
);

    logic [CNT_W-1:0] count_q;

    // Count register: reload on request, otherwise step down once per tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero_o = (count_q == '0);
    assign one_o  = (count_q == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/alarm_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_seq_ctrl
//  Description : Sequencing FSM for the alarm timer-set/compare datapath.
//                Loads the alarm target, re-samples live time on each 1 Hz
//                tick, evaluates the comparator and drives a bounded ring
//                period. All datapath strobes are registered Moore outputs.
//  Config      : define ALARM_SNOOZE_EN to enable the SNOOZE state and the
//                snooze_btn input.
//  Revision    : 1.0 - initial release
// ============================================================================
module alarm_seq_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int unsigned RING_SECS   = 60,
    parameter int unsigned SNOOZE_SECS = 300
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       set_req,
    input  logic       arm,
    input  logic       k7,
    input  logic       stop_btn,
    input  logic       snooze_btn,
    output logic       Kc,
    output logic       La,
    output logic       Lb,
    output logic       Ea,
    output logic       Lr,
    output logic       Er,
    output logic [1:0] s,
    output logic       ring,
    output logic       busy,
    output logic [3:0] state
);

    // Out-of-range periods are rejected at elaboration
    if ((RING_SECS < 1) || (RING_SECS > 255)) begin : g_bad_ring_secs
        $error("alarm_seq_ctrl: RING_SECS must be within 1..255");
    end
    if ((SNOOZE_SECS < 1) || (SNOOZE_SECS > 1023)) begin : g_bad_snooze_secs
        $error("alarm_seq_ctrl: SNOOZE_SECS must be within 1..1023");
    end

    localparam logic [CNT_W-1:0] RING_LOAD = RING_SECS[CNT_W-1:0];
`ifdef ALARM_SNOOZE_EN
    localparam logic [CNT_W-1:0] SNOOZE_LOAD = SNOOZE_SECS[CNT_W-1:0];
`else
    logic unused_snooze_btn;
    assign unused_snooze_btn = snooze_btn;
`endif

    state_t           state_q;
    state_t           state_d;
    logic             cnt_load_d;
    logic [CNT_W-1:0] cnt_val_d;
    logic             cnt_dec_d;
    logic             cnt_expire_d;
    logic             cnt_zero;
    logic             cnt_one;

    logic             kc_q;
    logic             la_q;
    logic             lb_q;
    logic             ea_q;
    logic             lr_q;
    logic             er_q;
    logic [1:0]       s_q;
    logic             ring_q;
    logic             busy_q;

    // The counter only advances on ticks seen while ringing or snoozing;
    // a count of one (or an already-empty count) ends the period on that tick
    assign cnt_dec_d    = tick_1hz && ((state_q == ST_RING) || (state_q == ST_SNOOZE));
    assign cnt_expire_d = tick_1hz && (cnt_one || cnt_zero);

    sec_counter u_sec_counter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load_d),
        .load_val_i (cnt_val_d),
        .dec_i      (cnt_dec_d),
        .zero_o     (cnt_zero),
        .one_o      (cnt_one)
    );

    // Next-state logic; priority set_req > arm low > stop > snooze > tick
    always_comb begin
        state_d    = state_q;
        cnt_load_d = 1'b0;
        cnt_val_d  = RING_LOAD;
        case (state_q)
            ST_IDLE: begin
                if (set_req) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                state_d = ST_LOAD_A;
            end
            ST_LOAD_A: begin
                state_d = arm ? ST_ARMED : ST_IDLE;
            end
            ST_ARMED: begin
                if (set_req)       state_d = ST_CLEAR;
                else if (!arm)     state_d = ST_IDLE;
                else if (tick_1hz) state_d = ST_LOAD_B;
            end
            // Ticks landing in the compare pipeline are dropped, not queued
            ST_LOAD_B: begin
                if (set_req)   state_d = ST_CLEAR;
                else if (!arm) state_d = ST_IDLE;
                else           state_d = ST_CMP;
            end
            ST_CMP: begin
                if (set_req)   state_d = ST_CLEAR;
                else if (!arm) state_d = ST_IDLE;
                else           state_d = ST_EVAL;
            end
            ST_EVAL: begin
                if (set_req) begin
                    state_d = ST_CLEAR;
                end else if (!arm) begin
                    state_d = ST_IDLE;
                end else if (k7) begin
                    state_d    = ST_RING;
                    cnt_load_d = 1'b1;
                    cnt_val_d  = RING_LOAD;
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_RING: begin
                if (set_req) begin
                    state_d = ST_CLEAR;
                end else if (!arm) begin
                    state_d = ST_IDLE;
                end else if (stop_btn) begin
                    state_d = ST_ARMED;
                end
`ifdef ALARM_SNOOZE_EN
                else if (snooze_btn) begin
                    state_d    = ST_SNOOZE;
                    cnt_load_d = 1'b1;
                    cnt_val_d  = SNOOZE_LOAD;
                end
`endif
                else if (cnt_expire_d) begin
                    state_d = ST_ARMED;
                end
            end
`ifdef ALARM_SNOOZE_EN
            ST_SNOOZE: begin
                if (set_req) begin
                    state_d = ST_CLEAR;
                end else if (!arm) begin
                    state_d = ST_IDLE;
                end else if (cnt_expire_d) begin
                    state_d    = ST_RING;
                    cnt_load_d = 1'b1;
                    cnt_val_d  = RING_LOAD;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with outputs decoded from the next state so every
    // strobe is a flop aligned with the state it belongs to
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            kc_q    <= 1'b0;
            la_q    <= 1'b0;
            lb_q    <= 1'b0;
            ea_q    <= 1'b0;
            lr_q    <= 1'b0;
            er_q    <= 1'b0;
            s_q     <= SEL_ENTRY;
            ring_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            kc_q    <= (state_d == ST_CLEAR);
            la_q    <= (state_d == ST_LOAD_A);
            lb_q    <= (state_d == ST_LOAD_B);
            ea_q    <= (state_d == ST_CMP);
            lr_q    <= (state_d == ST_CMP);
            er_q    <= (state_d == ST_LOAD_B) || (state_d == ST_EVAL);
            s_q     <= sel_for_state(state_d);
            ring_q  <= (state_d == ST_RING);
            busy_q  <= is_busy_state(state_d);
        end
    end

    assign Kc    = kc_q;
    assign La    = la_q;
    assign Lb    = lb_q;
    assign Ea    = ea_q;
    assign Lr    = lr_q;
    assign Er    = er_q;
    assign s     = s_q;
    assign ring  = ring_q;
    assign busy  = busy_q;
    assign state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_alarm_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alarm_seq_ctrl
//  Description : Directed self-checking bench for alarm_seq_ctrl with
//                RING_SECS=3 and SNOOZE_SECS=2. Behaviour follows
//                ALARM_SNOOZE_EN when it is defined for the build.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_1hz;
    logic       set_req;
    logic       arm;
    logic       k7;
    logic       stop_btn;
    logic       snooze_btn;
    logic       Kc, La, Lb, Ea, Lr, Er, ring, busy;
    logic [1:0] s;
    logic [3:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    // Observation word: state, Kc, La, Lb, Ea, Lr, Er, s[1:0], ring, busy
    logic [13:0] obs;
    assign obs = {state, Kc, La, Lb, Ea, Lr, Er, s, ring, busy};

    alarm_seq_ctrl #(
        .RING_SECS   (3),
        .SNOOZE_SECS (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_1hz   (tick_1hz),
        .set_req    (set_req),
        .arm        (arm),
        .k7         (k7),
        .stop_btn   (stop_btn),
        .snooze_btn (snooze_btn),
        .Kc         (Kc),
        .La         (La),
        .Lb         (Lb),
        .Ea         (Ea),
        .Lr         (Lr),
        .Er         (Er),
        .s          (s),
        .ring       (ring),
        .busy       (busy),
        .state      (state)
    );

    always #5 clk = ~clk;

    // Expected observation word for each state, taken from the output table
    function automatic logic [13:0] exp_of(input int st);
        logic [9:0] o;
        case (st)
            1:       o = 10'b1_0_0_0_0_0_00_0_1;
            2:       o = 10'b0_1_0_0_0_0_00_0_1;
            4:       o = 10'b0_0_1_0_0_1_01_0_1;
            5:       o = 10'b0_0_0_1_1_0_01_0_1;
            6:       o = 10'b0_0_0_0_0_1_01_0_1;
            7:       o = 10'b0_0_0_0_0_0_10_1_0;
            default: o = 10'b0;
        endcase
        return {4'(st), o};
    endfunction

    // Advance one clock and settle just after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive one clock with a tick pulse present
    task automatic tick_pulse();
        tick_1hz = 1'b1;
        cyc();
        tick_1hz = 1'b0;
    endtask

    // Walk from ARMED into RING via a matching compare
    task automatic enter_ring(input string tag);
        k7 = 1'b1;
        tick_pulse();
        cyc();
        cyc();
        cyc();
        k7 = 1'b0;
        n_checks++;
        if (obs !== exp_of(7)) begin
            n_fail++;
            $display("FAIL %s_enter_ring: got %h expected %h", tag, obs, exp_of(7));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) cyc();
        n_checks++;
        if (obs !== exp_of(0)) begin
            n_fail++;
            $display("FAIL reset_held: got %h expected %h", obs, exp_of(0));
        end
        rst = 1'b0;
        cyc();
        n_checks++;
        if (obs !== exp_of(0)) begin
            n_fail++;
            $display("FAIL reset_released: got %h expected %h", obs, exp_of(0));
        end
    endtask

    task automatic test_set();
        int seq [3] = '{1, 2, 3};
        arm     = 1'b1;
        set_req = 1'b1;
        cyc();
        set_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (obs !== exp_of(seq[i])) begin
                n_fail++;
                $display("FAIL set_step%0d: got %h expected %h", i, obs, exp_of(seq[i]));
            end
            if (i < 2) cyc();
        end
        cyc();
        n_checks++;
        if (obs !== exp_of(3)) begin
            n_fail++;
            $display("FAIL set_hold_armed: got %h expected %h", obs, exp_of(3));
        end
    endtask

    task automatic test_compare_nomatch();
        int seq [4] = '{4, 5, 6, 3};
        k7 = 1'b0;
        tick_pulse();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (obs !== exp_of(seq[i])) begin
                n_fail++;
                $display("FAIL nomatch_step%0d: got %h expected %h", i, obs, exp_of(seq[i]));
            end
            if (i < 3) cyc();
        end
    endtask

    task automatic test_ring_expire();
        enter_ring("expire");
        for (int t = 1; t <= 3; t++) begin
            cyc();
            n_checks++;
            if (ring !== 1'b1) begin
                n_fail++;
                $display("FAIL ring_before_tick%0d: got %b expected 1", t, ring);
            end
            tick_pulse();
        end
        n_checks++;
        if (obs !== exp_of(3)) begin
            n_fail++;
            $display("FAIL ring_expired: got %h expected %h", obs, exp_of(3));
        end
    endtask

    task automatic test_snooze();
        int exp_after [3];
`ifdef ALARM_SNOOZE_EN
        exp_after = '{8, 8, 7};
`else
        exp_after = '{7, 7, 7};
`endif
        enter_ring("snooze");
        snooze_btn = 1'b1;
        cyc();
        snooze_btn = 1'b0;
        n_checks++;
        if (obs !== exp_of(exp_after[0])) begin
            n_fail++;
            $display("FAIL snooze_entry: got %h expected %h", obs, exp_of(exp_after[0]));
        end
        for (int t = 1; t <= 2; t++) begin
            cyc();
            tick_pulse();
            n_checks++;
            if (obs !== exp_of(exp_after[t])) begin
                n_fail++;
                $display("FAIL snooze_tick%0d: got %h expected %h", t, obs, exp_of(exp_after[t]));
            end
        end
        stop_btn = 1'b1;
        cyc();
        stop_btn = 1'b0;
        n_checks++;
        if (obs !== exp_of(3)) begin
            n_fail++;
            $display("FAIL snooze_stop: got %h expected %h", obs, exp_of(3));
        end
    endtask

    task automatic test_simultaneous();
        enter_ring("stop_snooze");
        stop_btn   = 1'b1;
        snooze_btn = 1'b1;
        cyc();
        stop_btn   = 1'b0;
        snooze_btn = 1'b0;
        n_checks++;
        if (obs !== exp_of(3)) begin
            n_fail++;
            $display("FAIL stop_plus_snooze: got %h expected %h", obs, exp_of(3));
        end
        enter_ring("set_stop");
        set_req  = 1'b1;
        stop_btn = 1'b1;
        cyc();
        set_req  = 1'b0;
        stop_btn = 1'b0;
        n_checks++;
        if (obs !== exp_of(1)) begin
            n_fail++;
            $display("FAIL set_plus_stop: got %h expected %h", obs, exp_of(1));
        end
        cyc();
        cyc();
        n_checks++;
        if (obs !== exp_of(3)) begin
            n_fail++;
            $display("FAIL set_plus_stop_rearm: got %h expected %h", obs, exp_of(3));
        end
    endtask

    task automatic test_tick_drop();
        k7 = 1'b0;
        tick_pulse();
        tick_pulse();
        n_checks++;
        if (obs !== exp_of(5)) begin
            n_fail++;
            $display("FAIL tickdrop_cmp: got %h expected %h", obs, exp_of(5));
        end
        cyc();
        cyc();
        cyc();
        n_checks++;
        if (obs !== exp_of(3)) begin
            n_fail++;
            $display("FAIL tickdrop_no_queue: got %h expected %h", obs, exp_of(3));
        end
    endtask

    task automatic test_arm_drop();
        tick_pulse();
        cyc();
        n_checks++;
        if (obs !== exp_of(5)) begin
            n_fail++;
            $display("FAIL armdrop_in_cmp: got %h expected %h", obs, exp_of(5));
        end
        arm = 1'b0;
        cyc();
        n_checks++;
        if (obs !== exp_of(0)) begin
            n_fail++;
            $display("FAIL armdrop_idle: got %h expected %h", obs, exp_of(0));
        end
        arm     = 1'b1;
        set_req = 1'b1;
        cyc();
        set_req = 1'b0;
        cyc();
        cyc();
        n_checks++;
        if (obs !== exp_of(3)) begin
            n_fail++;
            $display("FAIL armdrop_rearm: got %h expected %h", obs, exp_of(3));
        end
    endtask

    task automatic test_rst_mid_ring();
        enter_ring("rst");
        cyc();
        rst = 1'b1;
        #1;
        n_checks++;
        if (obs !== exp_of(0)) begin
            n_fail++;
            $display("FAIL rst_mid_ring_async: got %h expected %h", obs, exp_of(0));
        end
        cyc();
        rst = 1'b0;
        cyc();
        n_checks++;
        if (obs !== exp_of(0)) begin
            n_fail++;
            $display("FAIL rst_mid_ring_after: got %h expected %h", obs, exp_of(0));
        end
    endtask

    initial begin
        rst        = 1'b1;
        tick_1hz   = 1'b0;
        set_req    = 1'b0;
        arm        = 1'b0;
        k7         = 1'b0;
        stop_btn   = 1'b0;
        snooze_btn = 1'b0;
        test_reset();
        test_set();
        test_compare_nomatch();
        test_ring_expire();
        test_snooze();
        test_simultaneous();
        test_tick_drop();
        test_arm_drop();
        test_rst_mid_ring();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
